// File: rtl/csr_trap_ctrl_if.sv
// Purpose: MW-stage bundle between the pipeline and the CSR/trap controller.
// Latency: wires only; timing is set by the endpoints.
// Backpressure: none; the pipeline presents one MW slot per clock.
interface csr_trap_ctrl_if;
  logic        mw_valid;
  logic [31:0] inst_mw;
  logic [31:0] rs1_mw;
  logic [31:0] pc_next_mw;
  logic        timer_irq;
  logic        ext_irq;
  logic [31:0] csr_rdata;
  logic [1:0]  interrupt;
  logic        is_mret_mw;
  logic        redirect;
  logic [31:0] redirect_pc;

  modport master (
    output mw_valid, inst_mw, rs1_mw, pc_next_mw, timer_irq, ext_irq,
    input  csr_rdata, interrupt, is_mret_mw, redirect, redirect_pc
  );

  modport slave (
    input  mw_valid, inst_mw, rs1_mw, pc_next_mw, timer_irq, ext_irq,
    output csr_rdata, interrupt, is_mret_mw, redirect, redirect_pc
  );
endinterface

// File: rtl/csr_trap_ctrl.sv
// Purpose: machine-mode CSR file plus interrupt-entry / mret sequencer for the MW stage.
// Latency: CSR read combinational; trap/mret outputs one edge after the MW decision, ext_irq adds SYNC_STAGES.
// Backpressure: none; interrupts seen during bubbles or the flushed slot stay pending until a valid RUN cycle.
module csr_trap_ctrl #(
  parameter logic [31:0] MTVEC_RST   = 32'h0000_0100,
  parameter int          SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst,
  csr_trap_ctrl_if.slave bus
);

  typedef enum logic [1:0] {RUN = 2'd0, TRAP = 2'd1, MRET = 2'd2} state_t;

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MIP     = 12'h344;
  localparam logic [31:0] MRET_INST    = 32'h3020_0073;
  localparam logic [6:0]  OPC_SYSTEM   = 7'b1110011;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] ext_sync;
  logic                   ext_synced;

  // architectural state; only implemented bits of mstatus/mie are stored
  logic        st_mie, st_mpie, ie_mtie, ie_meie;
  logic [31:0] mtvec, mepc, mcause;
  logic        st_mie_nxt, st_mpie_nxt, ie_mtie_nxt, ie_meie_nxt;
  logic [31:0] mtvec_nxt, mepc_nxt, mcause_nxt;

  logic [11:0] csr_addr;
  logic [2:0]  funct3;
  logic [4:0]  src_fld;
  logic        in_run, is_csr, csr_we, mret, take, ext_p, tim_p;
  logic [31:0] src_val, wval, mepc_rd;
  logic [4:0]  cause_code;
  logic [31:0] trap_base, trap_pc;

  logic [1:0]  interrupt_d;
  logic        is_mret_d, redirect_d;
  logic [31:0] redirect_pc_d;

  assign csr_addr   = bus.inst_mw[31:20];
  assign funct3     = bus.inst_mw[14:12];
  assign src_fld    = bus.inst_mw[19:15];
  assign ext_synced = ext_sync[SYNC_STAGES-1];
  assign in_run     = (state == RUN);
  assign is_csr     = (bus.inst_mw[6:0] == OPC_SYSTEM) && (funct3 != 3'b000);
  assign src_val    = funct3[2] ? {27'd0, src_fld} : bus.rs1_mw;

  // set/clear with a zero source field is a pure read; TRAP/MRET cycles hold the flushed slot
  assign csr_we = bus.mw_valid & in_run & is_csr &
                  ((funct3[1:0] == 2'b01) | (funct3[1] & (src_fld != 5'd0)));

  assign mret  = bus.mw_valid & in_run & (bus.inst_mw == MRET_INST);
  assign ext_p = ie_meie & ext_synced;
  assign tim_p = ie_mtie & bus.timer_irq;
  // pre-write MIE gates the trap, so a CSR write enabling MIE takes effect next cycle
  assign take  = st_mie & bus.mw_valid & (ext_p | tim_p) & ~mret & in_run;

  assign mepc_rd    = mepc & 32'hFFFF_FFFC;
  assign cause_code = ext_p ? 5'd11 : 5'd7;
  assign trap_base  = {mtvec_nxt[31:2], 2'b00};
  assign trap_pc    = (mtvec_nxt[1:0] == 2'b01) ? trap_base + {25'd0, cause_code, 2'b00}
                                                : trap_base;

  // combinational CSR read port; also the old value for set/clear
  always_comb begin
    bus.csr_rdata = 32'd0;
    case (csr_addr)
      ADDR_MSTATUS: bus.csr_rdata = {24'd0, st_mpie, 3'd0, st_mie, 3'd0};
      ADDR_MIE:     bus.csr_rdata = {20'd0, ie_meie, 3'd0, ie_mtie, 7'd0};
      ADDR_MTVEC:   bus.csr_rdata = mtvec;
      ADDR_MEPC:    bus.csr_rdata = mepc_rd;
      ADDR_MCAUSE:  bus.csr_rdata = mcause;
      ADDR_MIP:     bus.csr_rdata = {20'd0, ext_synced, 3'd0, bus.timer_irq, 7'd0};
      default:      bus.csr_rdata = 32'd0;
    endcase
  end

  // write data for CSRRW / CSRRS / CSRRC and immediate forms
  always_comb begin
    wval = bus.csr_rdata;
    case (funct3[1:0])
      2'b01:   wval = src_val;
      2'b10:   wval = bus.csr_rdata | src_val;
      2'b11:   wval = bus.csr_rdata & ~src_val;
      default: wval = bus.csr_rdata;
    endcase
  end

  // next CSR state: software write first, then trap/mret side effects win
  always_comb begin
    st_mie_nxt  = st_mie;
    st_mpie_nxt = st_mpie;
    ie_mtie_nxt = ie_mtie;
    ie_meie_nxt = ie_meie;
    mtvec_nxt   = mtvec;
    mepc_nxt    = mepc;
    mcause_nxt  = mcause;
    if (csr_we) begin
      case (csr_addr)
        ADDR_MSTATUS: begin st_mie_nxt = wval[3]; st_mpie_nxt = wval[7]; end
        ADDR_MIE:     begin ie_mtie_nxt = wval[7]; ie_meie_nxt = wval[11]; end
        ADDR_MTVEC:   mtvec_nxt  = wval;
        ADDR_MEPC:    mepc_nxt   = wval;
        ADDR_MCAUSE:  mcause_nxt = wval;
        default:      ;
      endcase
    end
    if (take) begin
      mepc_nxt    = bus.pc_next_mw;
      mcause_nxt  = {1'b1, 26'd0, cause_code};
      st_mpie_nxt = st_mie;
      st_mie_nxt  = 1'b0;
    end else if (mret) begin
      st_mie_nxt  = st_mpie;
      st_mpie_nxt = 1'b1;
    end
  end

  // CSR registers and ext_irq synchroniser
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_mie   <= 1'b0;
      st_mpie  <= 1'b0;
      ie_mtie  <= 1'b0;
      ie_meie  <= 1'b0;
      mtvec    <= MTVEC_RST;
      mepc     <= 32'd0;
      mcause   <= 32'd0;
      ext_sync <= '0;
    end else begin
      st_mie   <= st_mie_nxt;
      st_mpie  <= st_mpie_nxt;
      ie_mtie  <= ie_mtie_nxt;
      ie_meie  <= ie_meie_nxt;
      mtvec    <= mtvec_nxt;
      mepc     <= mepc_nxt;
      mcause   <= mcause_nxt;
      ext_sync <= {ext_sync[SYNC_STAGES-2:0], bus.ext_irq};
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // FSM next state: TRAP/MRET last exactly one cycle (the flushed slot)
  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (mret)      state_nxt = MRET;
        else if (take) state_nxt = TRAP;
      end
      TRAP:    state_nxt = RUN;
      MRET:    state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // FSM outputs, computed for the next edge
  always_comb begin
    interrupt_d   = 2'b00;
    is_mret_d     = 1'b0;
    redirect_d    = 1'b0;
    redirect_pc_d = 32'd0;
    if (take) begin
      interrupt_d   = 2'b01;
      redirect_d    = 1'b1;
      redirect_pc_d = trap_pc;
    end else begin
      if ((ext_p | tim_p) & ~st_mie) interrupt_d = 2'b10;
      if (mret) begin
        is_mret_d     = 1'b1;
        redirect_d    = 1'b1;
        redirect_pc_d = mepc_rd;
      end
    end
  end

  // registered flush/redirect outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.interrupt   <= 2'b00;
      bus.is_mret_mw  <= 1'b0;
      bus.redirect    <= 1'b0;
      bus.redirect_pc <= 32'd0;
    end else begin
      bus.interrupt   <= interrupt_d;
      bus.is_mret_mw  <= is_mret_d;
      bus.redirect    <= redirect_d;
      bus.redirect_pc <= redirect_pc_d;
    end
  end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Purpose: directed scoreboard bench for csr_trap_ctrl.
// Latency: each step's expectation is checked one edge after it is driven.
// Backpressure: none; stimulus and monitor run decoupled through a queue.
module tb_csr_trap_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  csr_trap_ctrl_if bus_if();

  csr_trap_ctrl #(.MTVEC_RST(32'h0000_0100), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  localparam logic [31:0] MRET_I = 32'h3020_0073;

  typedef struct {
    string       name;
    logic [1:0]  intr;
    logic        mret;
    logic        red;
    logic [31:0] rpc;
    logic        rchk;
    logic [31:0] rdat;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [31:0] csr_i(input logic [11:0] a, input logic [2:0] f3,
                                        input logic [4:0] s);
    return {a, s, f3, 5'd0, 7'b1110011};
  endfunction

  function automatic logic [31:0] rd_i(input logic [11:0] a);
    return csr_i(a, 3'b010, 5'd0);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // drive one MW slot and queue the response expected after the next edge
  task automatic step(input string nm, input logic v, input logic [31:0] inst,
                      input logic [31:0] rs1, input logic [31:0] pc,
                      input logic [1:0] ei, input logic em, input logic er,
                      input logic [31:0] erpc, input logic rc, input logic [31:0] rexp);
    exp_t e;
    bus_if.mw_valid   = v;
    bus_if.inst_mw    = inst;
    bus_if.rs1_mw     = rs1;
    bus_if.pc_next_mw = pc;
    e.name = nm; e.intr = ei; e.mret = em; e.red = er; e.rpc = erpc;
    e.rchk = rc; e.rdat = rexp;
    sbq.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // monitor: one expectation per clock while the queue holds entries
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk({e.name, ".interrupt"},   {30'd0, bus_if.interrupt}, {30'd0, e.intr});
        chk({e.name, ".is_mret_mw"},  {31'd0, bus_if.is_mret_mw}, {31'd0, e.mret});
        chk({e.name, ".redirect"},    {31'd0, bus_if.redirect}, {31'd0, e.red});
        chk({e.name, ".redirect_pc"}, bus_if.redirect_pc, e.rpc);
        if (e.rchk) chk({e.name, ".csr_rdata"}, bus_if.csr_rdata, e.rdat);
      end
    end
  end

  // stimulus
  initial begin
    rst = 1'b1;
    bus_if.mw_valid   = 1'b0;
    bus_if.inst_mw    = rd_i(12'h305);
    bus_if.rs1_mw     = 32'd0;
    bus_if.pc_next_mw = 32'd0;
    bus_if.timer_irq  = 1'b0;
    bus_if.ext_irq    = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    chk("rst.interrupt",   {30'd0, bus_if.interrupt}, 32'd0);
    chk("rst.redirect",    {31'd0, bus_if.redirect}, 32'd0);
    chk("rst.redirect_pc", bus_if.redirect_pc, 32'd0);
    chk("rst.mtvec",       bus_if.csr_rdata, 32'h100);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // reset values of every CSR plus an unimplemented address
    step("rd_mstatus", 0, rd_i(12'h300), 0, 0, 2'b00, 0, 0, 0, 1, 32'h0);
    step("rd_mie",     0, rd_i(12'h304), 0, 0, 2'b00, 0, 0, 0, 1, 32'h0);
    step("rd_mtvec",   0, rd_i(12'h305), 0, 0, 2'b00, 0, 0, 0, 1, 32'h100);
    step("rd_mepc",    0, rd_i(12'h341), 0, 0, 2'b00, 0, 0, 0, 1, 32'h0);
    step("rd_mcause",  0, rd_i(12'h342), 0, 0, 2'b00, 0, 0, 0, 1, 32'h0);
    step("rd_mip",     0, rd_i(12'h344), 0, 0, 2'b00, 0, 0, 0, 1, 32'h0);
    step("rd_unimpl",  0, rd_i(12'h7C0), 0, 0, 2'b00, 0, 0, 0, 1, 32'h0);

    // vectored mtvec, enable MIE and MTIE, then timer trap
    step("w_mtvec",   1, csr_i(12'h305, 3'b001, 5'd1), 32'h201, 0, 2'b00, 0, 0, 0, 1, 32'h201);
    step("si_mstat",  1, csr_i(12'h300, 3'b110, 5'd8), 0, 0, 2'b00, 0, 0, 0, 1, 32'h8);
    step("s_mie",     1, csr_i(12'h304, 3'b010, 5'd2), 32'h80, 0, 2'b00, 0, 0, 0, 1, 32'h80);
    bus_if.timer_irq = 1'b1;
    step("tim_trap",  1, rd_i(12'h341), 0, 32'h40, 2'b01, 0, 1, 32'h21C, 1, 32'h40);
    step("trap_slot", 1, rd_i(12'h342), 0, 32'h44, 2'b10, 0, 0, 0, 1, 32'h8000_0007);
    step("masked",    1, rd_i(12'h300), 0, 32'h44, 2'b10, 0, 0, 0, 1, 32'h80);
    step("mret1",     1, MRET_I, 0, 32'h44, 2'b10, 1, 1, 32'h40, 0, 0);
    step("mret_slot", 1, rd_i(12'h300), 0, 32'h44, 2'b00, 0, 0, 0, 1, 32'h88);
    step("retrap",    1, rd_i(12'h342), 0, 32'h44, 2'b01, 0, 1, 32'h21C, 1, 32'h8000_0007);
    bus_if.timer_irq = 1'b0;
    step("trap_slot2", 1, rd_i(12'h300), 0, 0, 2'b00, 0, 0, 0, 1, 32'h80);
    step("mret2",      1, MRET_I, 0, 0, 2'b00, 1, 1, 32'h44, 0, 0);
    step("blk_write",  1, csr_i(12'h304, 3'b010, 5'd3), 32'h800, 0, 2'b00, 0, 0, 0, 1, 32'h80);
    step("s_meie",     1, csr_i(12'h304, 3'b010, 5'd3), 32'h800, 0, 2'b00, 0, 0, 0, 1, 32'h880);

    // ext and timer together: bubbles while ext synchronises, ext wins
    bus_if.timer_irq = 1'b1;
    bus_if.ext_irq   = 1'b1;
    step("sync1",    0, rd_i(12'h344), 0, 32'h80, 2'b00, 0, 0, 0, 1, 32'h80);
    step("sync2",    0, rd_i(12'h344), 0, 32'h80, 2'b00, 0, 0, 0, 1, 32'h880);
    step("ext_trap", 1, rd_i(12'h342), 0, 32'h80, 2'b01, 0, 1, 32'h22C, 1, 32'h8000_000B);
    bus_if.timer_irq = 1'b0;
    bus_if.ext_irq   = 1'b0;
    step("ext_slot", 1, rd_i(12'h341), 0, 0, 2'b10, 0, 0, 0, 1, 32'h80);
    step("mret3",    1, MRET_I, 0, 0, 2'b10, 1, 1, 32'h80, 0, 0);
    step("mret3_sl", 0, rd_i(12'h300), 0, 0, 2'b00, 0, 0, 0, 1, 32'h88);

    // pending timer held through three bubbles
    bus_if.timer_irq = 1'b1;
    for (int i = 0; i < 3; i++)
      step("bubble", 0, rd_i(12'h342), 0, 32'h90, 2'b00, 0, 0, 0, 1, 32'h8000_000B);
    step("bub_trap", 1, rd_i(12'h341), 0, 32'h90, 2'b01, 0, 1, 32'h21C, 1, 32'h90);
    step("bub_slot", 1, rd_i(12'h300), 0, 0, 2'b10, 0, 0, 0, 1, 32'h80);
    step("w_mepc",   1, csr_i(12'h341, 3'b001, 5'd4), 32'h123, 0, 2'b10, 0, 0, 0, 1, 32'h120);
    step("c_zero",   1, csr_i(12'h300, 3'b011, 5'd0), 32'h80, 0, 2'b10, 0, 0, 0, 1, 32'h80);
    step("si_mie_b", 1, csr_i(12'h300, 3'b110, 5'd8), 0, 0, 2'b10, 0, 0, 0, 1, 32'h88);
    // CSR write to mcause in the trap cycle is overridden by the trap cause
    step("w_take",   1, csr_i(12'h342, 3'b001, 5'd5), 32'h55, 32'hA0, 2'b01, 0, 1, 32'h21C, 1,
         32'h8000_0007);

    // reset during the TRAP cycle clears outputs asynchronously
    rst = 1'b1;
    #1;
    chk("midtrap_rst.interrupt",   {30'd0, bus_if.interrupt}, 32'd0);
    chk("midtrap_rst.redirect",    {31'd0, bus_if.redirect}, 32'd0);
    chk("midtrap_rst.redirect_pc", bus_if.redirect_pc, 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    bus_if.timer_irq = 1'b0;
    step("post_mtvec",  0, rd_i(12'h305), 0, 0, 2'b00, 0, 0, 0, 1, 32'h100);
    step("post_mstat",  0, rd_i(12'h300), 0, 0, 2'b00, 0, 0, 0, 1, 32'h0);
    step("post_mcause", 0, rd_i(12'h342), 0, 0, 2'b00, 0, 0, 0, 1, 32'h0);

    // direct-mode mtvec: target is the base itself
    step("d_mstat",  1, csr_i(12'h300, 3'b110, 5'd8), 0, 0, 2'b00, 0, 0, 0, 1, 32'h8);
    step("d_mie",    1, csr_i(12'h304, 3'b010, 5'd2), 32'h80, 0, 2'b00, 0, 0, 0, 1, 32'h80);
    bus_if.timer_irq = 1'b1;
    step("d_trap",   1, rd_i(12'h341), 0, 32'hB0, 2'b01, 0, 1, 32'h100, 1, 32'hB0);
    bus_if.timer_irq = 1'b0;

    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clk);
    #2;
    if (sbq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
